param_cache_ctrl: RTL and testbench

//  Parametrised direct-mapped, write-back, write-allocate cache controller; next generation of the 8-bit
//  tt_um cache controller. Sits between a single requester (valid/ready request, one-cycle response pulse)
//  and a slower backing memory (req/ack handshake). Adds dirty write-back, explicit miss/refill sequencing,

---
 rtl/param_cache_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_param_cache_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache_ctrl.sv
// param_cache_ctrl: direct-mapped, write-back, write-allocate cache controller.
// One word per line. A single requester talks valid/ready and gets a one-cycle
// response pulse. A slower backing memory talks req/ack. Dirty victims are
// written back before the refill. A whole-cache invalidate is available in IDLE.
// Saturating hit/miss statistics are kept.
//
// Handshake semantics:
//   Requester side: a request transfers on a rising edge where req_valid and
//   req_ready are both high. req_ready is high only in IDLE with inv_all low.
//   resp_valid is a single-cycle pulse, and resp_hit/resp_rdata are meaningful
//   only while it is high.
//   Memory side: mem_req rises with mem_we/mem_addr/mem_wdata and holds them
//   stable until the edge where mem_ack is sampled high. mem_rdata is taken on
//   that same edge. mem_ack is ignored unless a memory phase is in progress.
module param_cache_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    input  logic              inv_all,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [2:0]        dbg_state
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_REFILL = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched request
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Line storage
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Response and statistics
    logic              r_resp_hit;
    logic [DATA_W-1:0] r_resp_rdata;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_victim_dirty;
    logic               w_accept;
    logic               w_mem_done;

    assign w_idx          = r_addr[INDEX_W-1:0];
    assign w_tag          = r_addr[ADDR_W-1:INDEX_W];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_accept       = (r_state == S_IDLE) && req_valid && !inv_all;
    assign w_mem_done     = (r_state == S_REFILL) && mem_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = !inv_all;
                if (w_accept) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_next = S_RESP;
                end else if (w_victim_dirty) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_REFILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_idx], w_idx};
                mem_wdata = r_data[w_idx];
                if (mem_ack) begin
                    w_next = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (mem_ack) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the request on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Valid/dirty bits: reset, invalidate, write-hit marking, install on refill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if ((r_state == S_IDLE) && inv_all) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if ((r_state == S_LOOKUP) && w_hit && r_we) begin
            r_dirty[w_idx] <= 1'b1;
        end else if (w_mem_done) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= r_we;
        end
    end

    // Tag/data arrays need no reset: contents are qualified by r_valid
    always_ff @(posedge clk) begin
        if ((r_state == S_LOOKUP) && w_hit && r_we) begin
            r_data[w_idx] <= r_wdata;
        end else if (w_mem_done) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= r_we ? r_wdata : mem_rdata;
        end
    end

    // Response word and hit flag, prepared before the RESP cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= '0;
        end else if (r_state == S_LOOKUP) begin
            r_resp_hit   <= w_hit;
            r_resp_rdata <= r_we ? r_wdata : r_data[w_idx];
        end else if (w_mem_done) begin
            r_resp_rdata <= r_we ? r_wdata : mem_rdata;
        end
    end

    // Saturating statistics, bumped once per completed transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_RESP) begin
            if (r_resp_hit) begin
                if (r_hit_cnt != {CNT_W{1'b1}}) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end else begin
                if (r_miss_cnt != {CNT_W{1'b1}}) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
        end
    end

    assign resp_hit   = r_resp_hit;
    assign resp_rdata = r_resp_rdata;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_param_cache_ctrl.sv
// Directed bench for param_cache_ctrl (8-bit address/data, 4 lines).
// The backing memory acks after 3 cycles of mem_req and returns mem[a] = a ^ 8'hFF.
module tb_param_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_hit;
  logic        inv_all = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // Memory-model bookkeeping
  int         wb_cnt = 0;
  int         rf_cnt = 0;
  int         mem_req_cycles = 0;
  int         mcnt = 0;
  logic [7:0] last_wb_addr = '0;
  logic [7:0] last_wb_data = '0;
  logic [7:0] last_rf_addr = '0;

  param_cache_ctrl #(.ADDR_W(8), .DATA_W(8), .INDEX_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .inv_all(inv_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Backing memory: ack raised on the 3rd falling edge with mem_req high
  initial begin : mem_model
    forever begin
      @(negedge clk);
      if (mem_req) mem_req_cycles++;
      if (rst || !mem_req || mem_ack) begin
        mem_ack = 1'b0;
        mcnt = 0;
      end else begin
        mcnt++;
        if (mcnt == 3) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr ^ 8'hFF;
          if (mem_we) begin
            wb_cnt++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
          end else begin
            rf_cnt++;
            last_rf_addr = mem_addr;
          end
        end
      end
    end
  end

  // Driver: issue one request, wait for the response pulse.
  // lat counts rising edges from the accept edge (=1) to the edge that raises resp_valid.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic hit, output logic [7:0] rdata, output int lat,
                        output logic after_pulse);
    int guard;
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    @(posedge clk);
    lat = 1;
    #1;
    req_valid = 1'b0;
    while (!resp_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    n_checks++;
    if (!resp_valid) begin
      n_fail++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within %0d cycles", addr, lat);
    end
    hit = resp_hit;
    rdata = resp_rdata;
    @(posedge clk); #1;
    after_pulse = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req_ready=%b mem_req=%b resp_valid=%b, need 1/0/0",
               req_ready, mem_req, resp_valid);
    end
    n_checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: hit_cnt=%0d miss_cnt=%0d, need 0/0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_cold_write_miss();
    logic h, p; logic [7:0] d; int lat; int wb0, rf0;
    wb0 = wb_cnt; rf0 = rf_cnt;
    do_req(1'b1, 8'h04, 8'hA5, h, d, lat, p);
    n_checks++;
    if (h !== 1'b0 || d !== 8'hA5) begin
      n_fail++;
      $display("FAIL cold_wr_resp: hit=%b rdata=%h, need 0/a5", h, d);
    end
    n_checks++;
    if (wb_cnt != wb0 || rf_cnt != rf0 + 1 || last_rf_addr !== 8'h04) begin
      n_fail++;
      $display("FAIL cold_wr_mem: wb=%0d refills=%0d rf_addr=%h, need 0/1/04",
               wb_cnt - wb0, rf_cnt - rf0, last_rf_addr);
    end
    n_checks++;
    if (lat != 5 || p !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_wr_timing: lat=%0d pulse_after=%b, need 5/0", lat, p);
    end
    n_checks++;
    if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cold_wr_cnt: hit=%0d miss=%0d, need 0/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_read_hit();
    logic h, p; logic [7:0] d; int lat; int mc0;
    mc0 = mem_req_cycles;
    do_req(1'b0, 8'h04, 8'h00, h, d, lat, p);
    n_checks++;
    if (h !== 1'b1 || d !== 8'hA5) begin
      n_fail++;
      $display("FAIL rd_hit_resp: hit=%b rdata=%h, need 1/a5", h, d);
    end
    n_checks++;
    if (lat != 2 || p !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_hit_latency: lat=%0d pulse_after=%b, need 2/0", lat, p);
    end
    n_checks++;
    if (mem_req_cycles != mc0 || hit_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rd_hit_nomem: mem_req cycles=%0d hit_cnt=%0d, need 0/1",
               mem_req_cycles - mc0, hit_cnt);
    end
  endtask

  task automatic test_dirty_evict(input logic [7:0] addr, input logic [7:0] victim_addr,
                                  input logic [7:0] victim_data, input logic [15:0] exp_miss);
    logic h, p; logic [7:0] d; int lat; int wb0, rf0;
    wb0 = wb_cnt; rf0 = rf_cnt;
    do_req(1'b0, addr, 8'h00, h, d, lat, p);
    n_checks++;
    if (wb_cnt != wb0 + 1 || last_wb_addr !== victim_addr || last_wb_data !== victim_data) begin
      n_fail++;
      $display("FAIL evict_wb: wb=%0d addr=%h data=%h, need 1/%h/%h",
               wb_cnt - wb0, last_wb_addr, last_wb_data, victim_addr, victim_data);
    end
    n_checks++;
    if (rf_cnt != rf0 + 1 || last_rf_addr !== addr) begin
      n_fail++;
      $display("FAIL evict_refill: refills=%0d addr=%h, need 1/%h", rf_cnt - rf0, last_rf_addr, addr);
    end
    n_checks++;
    if (h !== 1'b0 || d !== (addr ^ 8'hFF) || lat != 9) begin
      n_fail++;
      $display("FAIL evict_resp: hit=%b rdata=%h lat=%0d, need 0/%h/9", h, d, lat, addr ^ 8'hFF);
    end
    n_checks++;
    if (miss_cnt !== exp_miss) begin
      n_fail++;
      $display("FAIL evict_cnt: miss_cnt=%0d, need %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_inv_all();
    logic h, p; logic [7:0] d; int lat; int wb0; logic seen;
    @(negedge clk); #1;
    inv_all = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h08;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_ready: req_ready=%b, need 0", req_ready);
    end
    @(posedge clk); #1;
    inv_all = 1'b0; req_valid = 1'b0;
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL inv_no_accept: state=%0d, need 0", dbg_state);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_no_resp: resp_valid seen=%b, need 0", seen);
    end
    wb0 = wb_cnt;
    do_req(1'b0, 8'h08, 8'h00, h, d, lat, p);
    n_checks++;
    if (h !== 1'b0 || d !== 8'hF7 || wb_cnt != wb0 || lat != 5) begin
      n_fail++;
      $display("FAIL inv_remiss: hit=%b rdata=%h wb=%0d lat=%0d, need 0/f7/0/5",
               h, d, wb_cnt - wb0, lat);
    end
  endtask

  task automatic test_write_hit(input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [15:0] exp_hit);
    logic h, p; logic [7:0] d; int lat; int mc0;
    mc0 = mem_req_cycles;
    do_req(1'b1, addr, wdata, h, d, lat, p);
    n_checks++;
    if (h !== 1'b1 || d !== wdata || lat != 2 || mem_req_cycles != mc0) begin
      n_fail++;
      $display("FAIL wr_hit: hit=%b rdata=%h lat=%0d memcyc=%0d, need 1/%h/2/0",
               h, d, lat, mem_req_cycles - mc0, wdata);
    end
    n_checks++;
    if (hit_cnt !== exp_hit) begin
      n_fail++;
      $display("FAIL wr_hit_cnt: hit_cnt=%0d, need %0d", hit_cnt, exp_hit);
    end
  endtask

  task automatic test_reset_mid_refill();
    logic h, p; logic [7:0] d; int lat; int guard; int wb0; logic seen;
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (!mem_req && guard < 20);
    n_checks++;
    if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 8'h11)) begin
      n_fail++;
      $display("FAIL midrst_refill: mem_req=%b we=%b addr=%h, need 1/0/11", mem_req, mem_we, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_abandon: mem_req=%b resp_valid=%b state=%0d, need 0/0/0",
               mem_req, resp_valid, dbg_state);
    end
    n_checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_cnt: hit=%0d miss=%0d, need 0/0", hit_cnt, miss_cnt);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid || mem_req) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: activity seen=%b, need 0", seen);
    end
    // Line 0 held dirty 0x0C before reset; it must now miss without a write-back
    wb0 = wb_cnt;
    do_req(1'b0, 8'h0C, 8'h00, h, d, lat, p);
    n_checks++;
    if (h !== 1'b0 || d !== 8'hF3 || wb_cnt != wb0 || miss_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_invalid: hit=%b rdata=%h wb=%0d miss=%0d, need 0/f3/0/1",
               h, d, wb_cnt - wb0, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cold_write_miss();
    test_read_hit();
    test_dirty_evict(8'h08, 8'h04, 8'hA5, 16'd2);
    test_inv_all();
    test_write_hit(8'h08, 8'h3C, 16'd2);
    test_dirty_evict(8'h0C, 8'h08, 8'h3C, 16'd4);
    test_write_hit(8'h0C, 8'h55, 16'd3);
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
